ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard. It runs the full host-request sequence: clock inhibit, start bit, 8 data bits LSB first, odd parity, stop bit and device ack. It sits beside the existing scan-code receive path, sharing the same two open-collector PS/2 pins through open-drain enables at the top level.

## Interface
Parameters:
- CLK_HZ, 50_000_000, system clock frequency (documentation only).
- INHIBIT_CYCLES, 5000, cycles the clock line is held low before the start bit (100 µs at 50 MHz).
- TIMEOUT_CYCLES, 750_000, frame timeout measured from REQ entry (15 ms at 50 MHz).
- FILTER_LEN, 8, consecutive identical samples required before a filtered line changes.

Ports:
- clock  in  1  system clock. One clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- tx_data  in  8  command byte, sampled when tx_start is accepted.
- tx_start  in  1  request pulse. Accepted only in IDLE.
- ps2_clk_in  in  1  raw PS/2 clock pin level (asynchronous).
- ps2_data_in  in  1  raw PS/2 data pin level (asynchronous).
- ps2_clk_oe  out  1  1 = drive PS/2 clock low, 0 = release.
- ps2_data_oe  out  1  1 = drive PS/2 data low, 0 = release.
- tx_busy  out  1  high from the cycle after acceptance until completion or error.
- tx_done  out  1  one-cycle pulse: byte acked and both lines are back high.
- tx_error  out  1  one-cycle pulse: no ack, or timeout.

## Operation
- Input conditioning: each pin uses a 2-flop synchronizer followed by the FILTER_LEN filter. Falling edge = filtered clock goes 1→0. A filter reset value is 1.
- Parity: par = ~^tx_data (odd), latched together with the byte at acceptance.
- States (enum in package):
  - IDLE: oe outputs 0.
  - INHIBIT: clk_oe=1, data_oe=0, for INHIBIT_CYCLES cycles.
  - REQ: clk_oe=0, data_oe=1 (start bit). Waits for the 1st falling edge.
  - BITS: falling edges 1..8 set data_oe=~tx_data[edge-1]. Edge 9 sets data_oe=~par. Edge 10 sets data_oe=0 (stop bit).
  - ACK: on falling edge 11, sample filtered data. 0 → WAIT_IDLE. 1 → error.
  - WAIT_IDLE: waits until filtered clock and data are both 1, then pulses tx_done and returns to IDLE.
- Edge counter: 4 bits, cleared on REQ entry.
- Timeout counter: cleared on REQ entry, runs through REQ/BITS/ACK/WAIT_IDLE. Reaching TIMEOUT_CYCLES → error from any of those states.
- Error: both oe outputs 0 in the same cycle tx_error pulses; next state IDLE.
- tx_done and tx_error are mutually exclusive.
- tx_start while busy: ignored, with no effect on the frame in progress.
- Falling edges in IDLE: ignored. Device-to-host frames belong to the receiver.
- Reset (including mid-frame): state IDLE, all outputs 0, so both lines are released asynchronously. Counters clear; filters reset to 1.

## Timing
- tx_start high at cycle 0 → tx_busy=1 and clk_oe=1 at cycle 1.
- clk_oe stays high for exactly INHIBIT_CYCLES cycles. At cycle 1+INHIBIT_CYCLES: clk_oe=0, data_oe=1.
- data_oe updates on the cycle after the filter reports a falling edge. Total pin-to-output latency is 2 + FILTER_LEN + 1 cycles, well inside the ~40 µs clock-low half-period.
- tx_done/tx_error pulse and tx_busy fall are registered in the same cycle.
- All outputs are registered; there is no combinational path from pins to outputs.

## Structure
- Package ps2_pkg: state enum (IDLE, INHIBIT, REQ, BITS, ACK, WAIT_IDLE) and PS2_ACK_EDGE=11. Shared with the receive path.
- Sub-module ps2_line_filter: synchronizer, FILTER_LEN filter, filtered level and falling-edge outputs. Instantiated twice (clock, data) and reusable by the receiver.

## Test plan
Device model: 12.5 kHz clock generator and ack driver.
- Send 0xED, device acks → data bits observed on successive edges 1,0,1,1,0,1,1,1, then parity 1 and stop released. Edge 11 sees ack low. Then tx_done=1 for one cycle, tx_busy=0, tx_error never high.
- Send 0x01 → parity bit 0. Send 0x00 → parity bit 1. Both end in tx_done.
- Device releases data at edge 11 (no ack) → tx_error pulse one cycle after the filtered edge; both oe outputs 0; no tx_done.
- TIMEOUT_CYCLES=2000 and device never clocks → clk_oe high for INHIBIT_CYCLES, then tx_error exactly 2000 cycles after REQ entry; lines released.
- Second tx_start mid-frame with 0x55 → ignored; transmitted bits remain the first byte.
- Reset asserted at edge 5 → oe outputs 0 without waiting for a clock edge. A new 0xFF after reset completes normally.
- Clock-pin glitch low for FILTER_LEN-1 cycles during BITS → no edge counted; frame completes correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: definitions shared by the PS/2 host transmitter and the scan-code
// receive path.
//   ps2_state_e       : host-to-device frame states
//   PS2_*_EDGE        : falling-edge numbers of the host-to-device frame
//   odd_parity()      : parity bit that makes data + parity an odd count of ones
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      REQ,
      BITS,
      ACK,
      WAIT_IDLE
   } ps2_state_e;

   // Falling edges 1..8 carry the data bits, 9 parity, 10 stop, 11 device ack.
   localparam logic [3:0] PS2_LAST_DATA_EDGE = 4'd8;
   localparam logic [3:0] PS2_PARITY_EDGE    = 4'd9;
   localparam logic [3:0] PS2_STOP_EDGE      = 4'd10;
   localparam logic [3:0] PS2_ACK_EDGE       = 4'd11;

   function automatic logic odd_parity(input logic [7:0] b);
      return ~^b;
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: conditions one raw PS/2 pin.
//   clock  : system clock
//   reset  : asynchronous active-high reset (filtered level resets to 1)
//   pin_in : raw, asynchronous pin level
//   level  : filtered level; changes only after FILTER_LEN consecutive
//            synchronized samples disagree with it
//   fall   : one-cycle pulse, registered together with a 1->0 level change
module ps2_line_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clock,
   input  logic reset,
   input  logic pin_in,
   output logic level,
   output logic fall
);

   localparam int CW = $clog2(FILTER_LEN + 1);
   localparam logic [CW-1:0] RUN_LAST = CW'(FILTER_LEN - 1);

   logic [1:0]    sync_q, sync_d;   // [0] first stage, [1] second stage
   logic          level_q, level_d;
   logic          fall_q, fall_d;
   logic [CW-1:0] run_q, run_d;     // disagreeing samples seen so far

   always_comb begin
      sync_d  = {sync_q[0], pin_in};
      level_d = level_q;
      fall_d  = 1'b0;
      run_d   = '0;
      if (sync_q[1] != level_q) begin
         // This sample is the FILTER_LEN-th disagreeing one in a row.
         if (run_q == RUN_LAST) begin
            level_d = sync_q[1];
            fall_d  = ~sync_q[1];
         end else begin
            run_d = run_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_q  <= 2'b11;
         level_q <= 1'b1;
         fall_q  <= 1'b0;
         run_q   <= '0;
      end else begin
         sync_q  <= sync_d;
         level_q <= level_d;
         fall_q  <= fall_d;
         run_q   <= run_d;
      end
   end

   assign level = level_q;
   assign fall  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter. Sends one command byte:
// clock inhibit, start bit, 8 data bits LSB first, odd parity, stop, device ack.
//   clock, reset              : system clock, asynchronous active-high reset
//   tx_data, tx_start         : command byte and request pulse (taken in IDLE only)
//   ps2_clk_in, ps2_data_in   : raw pin levels
//   ps2_clk_oe, ps2_data_oe   : 1 = pull the pin low, 0 = release
//   tx_busy                   : frame in progress
//   tx_done, tx_error         : one-cycle completion / failure pulses
// All outputs come straight from flops.
module ps2_host_tx #(
   parameter int CLK_HZ         = 50_000_000,
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 750_000,
   parameter int FILTER_LEN     = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_start,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_error
);

   import ps2_pkg::*;

   // One counter serves the inhibit phase and the frame timeout; they never overlap.
   localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic clk_level, clk_fall, data_level, unused_data_fall;

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
      .clock  (clock),
      .reset  (reset),
      .pin_in (ps2_clk_in),
      .level  (clk_level),
      .fall   (clk_fall)
   );

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
      .clock  (clock),
      .reset  (reset),
      .pin_in (ps2_data_in),
      .level  (data_level),
      .fall   (unused_data_fall)
   );

   ps2_state_e       state_q, state_d;
   logic [7:0]       byte_q, byte_d;     // shifts right as bits go out
   logic             par_q, par_d;
   logic [3:0]       edge_q, edge_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             clk_oe_q, clk_oe_d;
   logic             data_oe_q, data_oe_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             error_q, error_d;
   logic [3:0]       next_edge;

   assign next_edge = edge_q + 4'd1;

   always_comb begin
      state_d   = state_q;
      byte_d    = byte_q;
      par_d     = par_q;
      edge_d    = edge_q;
      cnt_d     = cnt_q;
      clk_oe_d  = clk_oe_q;
      data_oe_d = data_oe_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      error_d   = 1'b0;

      case (state_q)
         IDLE: begin
            // Clock falls here belong to device-to-host traffic; ignore them.
            if (tx_start) begin
               state_d   = INHIBIT;
               byte_d    = tx_data;
               par_d     = odd_parity(tx_data);
               cnt_d     = '0;
               busy_d    = 1'b1;
               clk_oe_d  = 1'b1;
               data_oe_d = 1'b0;
            end
         end

         INHIBIT: begin
            if (cnt_q == INHIBIT_LAST) begin
               state_d   = REQ;
               cnt_d     = '0;
               edge_d    = '0;
               clk_oe_d  = 1'b0;
               data_oe_d = 1'b1;   // start bit
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: begin
            // REQ, BITS, ACK, WAIT_IDLE: all covered by the frame timeout.
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == TIMEOUT_LAST) begin
               state_d   = IDLE;
               clk_oe_d  = 1'b0;
               data_oe_d = 1'b0;
               busy_d    = 1'b0;
               error_d   = 1'b1;
            end else begin
               case (state_q)
                  REQ, BITS: begin
                     if (clk_fall) begin
                        edge_d  = next_edge;
                        state_d = BITS;
                        if (next_edge <= PS2_LAST_DATA_EDGE) begin
                           data_oe_d = ~byte_q[0];
                           byte_d    = {1'b0, byte_q[7:1]};
                        end else if (next_edge == PS2_PARITY_EDGE) begin
                           data_oe_d = ~par_q;
                        end else begin
                           // Stop edge: release data so the device can ack.
                           data_oe_d = 1'b0;
                           state_d   = ACK;
                        end
                     end
                  end

                  ACK: begin
                     if (clk_fall && next_edge == PS2_ACK_EDGE) begin
                        edge_d = next_edge;
                        if (!data_level) begin
                           state_d = WAIT_IDLE;
                        end else begin
                           state_d   = IDLE;
                           clk_oe_d  = 1'b0;
                           data_oe_d = 1'b0;
                           busy_d    = 1'b0;
                           error_d   = 1'b1;
                        end
                     end
                  end

                  WAIT_IDLE: begin
                     if (clk_level && data_level) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                     end
                  end

                  default: begin
                     state_d = state_q;
                  end
               endcase
            end
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         byte_q    <= '0;
         par_q     <= 1'b0;
         edge_q    <= '0;
         cnt_q     <= '0;
         clk_oe_q  <= 1'b0;
         data_oe_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         byte_q    <= byte_d;
         par_q     <= par_d;
         edge_q    <= edge_d;
         cnt_q     <= cnt_d;
         clk_oe_q  <= clk_oe_d;
         data_oe_q <= data_oe_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         error_q   <= error_d;
      end
   end

   assign ps2_clk_oe  = clk_oe_q;
   assign ps2_data_oe = data_oe_q;
   assign tx_busy     = busy_q;
   assign tx_done     = done_q;
   assign tx_error    = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: randomized bench for ps2_host_tx with a PS/2 device model
// (clock generator, bit sampler, ack driver) on open-drain lines.
module tb_ps2_host_tx;

   localparam int INH = 40;
   localparam int TMO = 2000;
   localparam int FL  = 8;

   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_error;
   logic       dev_clk_low, dev_data_low;
   logic       ps2_clk_line, ps2_data_line;

   assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
   assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

   always #5 clock = ~clock;

   ps2_host_tx #(
      .CLK_HZ         (50_000_000),
      .INHIBIT_CYCLES (INH),
      .TIMEOUT_CYCLES (TMO),
      .FILTER_LEN     (FL)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .tx_data     (tx_data),
      .tx_start    (tx_start),
      .ps2_clk_in  (ps2_clk_line),
      .ps2_data_in (ps2_data_line),
      .ps2_clk_oe  (ps2_clk_oe),
      .ps2_data_oe (ps2_data_oe),
      .tx_busy     (tx_busy),
      .tx_done     (tx_done),
      .tx_error    (tx_error)
   );

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int exp_done = 0;
   int exp_err = 0;

   always @(posedge clock) cyc <= cyc + 1;

   // Pulse / line monitor, sampled on the falling clock edge.
   int n_done = 0, n_err = 0, n_done_cyc = 0, n_err_cyc = 0, n_both = 0;
   int n_busy_at_pulse = 0, n_oe_at_err = 0;
   int err_cyc = 0, req_cyc = 0, inh_run = 0, last_inh = 0, edge11_cyc = 0;
   logic done_prev = 1'b0, err_prev = 1'b0, clk_oe_prev = 1'b0, data_oe_prev = 1'b0;

   always @(negedge clock) begin
      if (tx_done) n_done_cyc++;
      if (tx_error) n_err_cyc++;
      if (tx_done && !done_prev) n_done++;
      if (tx_error && !err_prev) begin
         n_err++;
         err_cyc = cyc;
      end
      if (tx_done && tx_error) n_both++;
      if ((tx_done || tx_error) && tx_busy) n_busy_at_pulse++;
      if (tx_error && (ps2_clk_oe || ps2_data_oe)) n_oe_at_err++;
      if (ps2_clk_oe) inh_run++;
      else if (clk_oe_prev) begin
         last_inh = inh_run;
         inh_run  = 0;
      end
      if (ps2_data_oe && !data_oe_prev && clk_oe_prev) req_cyc = cyc;
      done_prev    = tx_done;
      err_prev     = tx_error;
      clk_oe_prev  = ps2_clk_oe;
      data_oe_prev = ps2_data_oe;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", tag, got, exp);
      end
   endtask

   // Reference: frame bits as the device sees them after edges 1..10.
   function automatic logic [9:0] model_bits(input logic [7:0] b);
      logic par;
      par = ($countones(b) % 2 == 0);
      return {1'b1, par, b};
   endfunction

   task automatic start_tx(input logic [7:0] b);
      @(negedge clock);
      tx_data  = b;
      tx_start = 1'b1;
      @(negedge clock);
      tx_start = 1'b0;
      chk("busy_cycle1", tx_busy, 1);
      chk("clk_oe_cycle1", ps2_clk_oe, 1);
   endtask

   // Device side of one host-to-device frame.
   task automatic dev_frame(input logic [7:0] b, input int half, input bit ack,
                            input int glitch_k, input int rst_k, input bit extra,
                            output logic [9:0] seen, output logic start_bit,
                            output bit aborted);
      int w;
      seen      = '0;
      start_bit = 1'b1;
      aborted   = 1'b0;
      w = 0;
      while (!(ps2_clk_line && !ps2_data_line) && w < 5000) begin
         @(negedge clock);
         w++;
      end
      if (w >= 5000) begin
         chk("req_wait_timeout", 0, 1);
         aborted = 1'b1;
         return;
      end
      start_bit = ps2_data_line;
      repeat (10) @(negedge clock);
      for (int k = 1; k <= 11; k++) begin
         dev_clk_low = 1'b1;
         if (k == 11) edge11_cyc = cyc;
         for (int c = 0; c < half; c++) begin
            @(negedge clock);
            tx_start = (extra && k == 3 && c == 0);
            if (extra && k == 3 && c == 0) tx_data = 8'h55;
            if (k == 1 && c == FL + 1) chk("data_lat_pre", ps2_data_oe, 1);
            if (k == 1 && c == FL + 2) chk("data_lat_post", ps2_data_oe, {31'd0, ~b[0]});
            if (rst_k == k && c == half / 2) begin
               #2 reset = 1'b1;
               #1;
               chk("rst_async_clk_oe", ps2_clk_oe, 0);
               chk("rst_async_data_oe", ps2_data_oe, 0);
               chk("rst_async_busy", tx_busy, 0);
               @(negedge clock);
               dev_clk_low  = 1'b0;
               dev_data_low = 1'b0;
               repeat (4) @(negedge clock);
               reset   = 1'b0;
               aborted = 1'b1;
               return;
            end
         end
         dev_clk_low = 1'b0;
         if (k <= 10) seen[k-1] = ps2_data_line;
         if (k == 10 && ack) dev_data_low = 1'b1;
         for (int c = 0; c < half; c++) begin
            @(negedge clock);
            dev_clk_low = (glitch_k == k && c >= 5 && c < 5 + FL - 1);
            if (k == 11 && c == 3) dev_data_low = 1'b0;
         end
      end
   endtask

   task automatic run_frame(input logic [7:0] b, input bit ack, input int half,
                            input int glitch_k, input int rst_k, input bit extra);
      logic [9:0] seen;
      logic       sb;
      bit         ab;
      int         d0, e0, w;
      d0 = n_done;
      e0 = n_err;
      start_tx(b);
      dev_frame(b, half, ack, glitch_k, rst_k, extra, seen, sb, ab);
      if (ab) begin
         $display("frame byte=%02h aborted by reset at edge %0d", b, rst_k);
         return;
      end
      w = 0;
      while (n_done == d0 && n_err == e0 && w < 1000) begin
         @(negedge clock);
         w++;
      end
      repeat (3) @(negedge clock);
      if (ack) exp_done++;
      else exp_err++;
      chk("start_bit", sb, 0);
      chk($sformatf("bits_%02h", b), seen, model_bits(b));
      chk("inhibit_len", last_inh, INH);
      chk("done_delta", n_done - d0, ack ? 1 : 0);
      chk("err_delta", n_err - e0, ack ? 0 : 1);
      if (!ack) chk("noack_err_latency", err_cyc - edge11_cyc, FL + 3);
      chk("end_busy", tx_busy, 0);
      chk("end_clk_oe", ps2_clk_oe, 0);
      chk("end_data_oe", ps2_data_oe, 0);
      $display("frame byte=%02h ack=%0d half=%0d glitch=%0d extra=%0d bits=%03h done=%0d err=%0d",
               b, ack, half, glitch_k, extra, seen, n_done - d0, n_err - e0);
   endtask

   initial begin
      logic [7:0] rb;
      int         w, e0, d0;
      reset        = 1'b1;
      tx_data      = 8'h00;
      tx_start     = 1'b0;
      dev_clk_low  = 1'b0;
      dev_data_low = 1'b0;
      repeat (4) @(negedge clock);
      chk("rst_clk_oe", ps2_clk_oe, 0);
      chk("rst_data_oe", ps2_data_oe, 0);
      chk("rst_busy", tx_busy, 0);
      chk("rst_done", tx_done, 0);
      chk("rst_error", tx_error, 0);
      reset = 1'b0;
      repeat (20) @(negedge clock);

      run_frame(8'hED, 1, 30, 0, 0, 0);
      run_frame(8'h01, 1, 28, 0, 0, 0);
      run_frame(8'h00, 1, 33, 0, 0, 0);
      run_frame(8'h96, 0, 30, 0, 0, 0);

      // Device never clocks: timeout measured from REQ entry.
      d0 = n_done;
      e0 = n_err;
      start_tx(8'h3C);
      w = 0;
      while (n_err == e0 && w < INH + TMO + 300) begin
         @(negedge clock);
         w++;
      end
      repeat (3) @(negedge clock);
      exp_err++;
      chk("tmo_err_delta", n_err - e0, 1);
      chk("tmo_done_delta", n_done - d0, 0);
      chk("tmo_inhibit_len", last_inh, INH);
      chk("tmo_cycles", err_cyc - req_cyc, TMO);
      chk("tmo_clk_oe", ps2_clk_oe, 0);
      chk("tmo_data_oe", ps2_data_oe, 0);
      $display("timeout byte=3c inhibit=%0d err_after_req=%0d", last_inh, err_cyc - req_cyc);

      run_frame(8'hA3, 1, 30, 0, 0, 1);     // 0x55 request mid-frame
      run_frame(8'h00, 1, 30, 0, 5, 0);     // reset at edge 5
      repeat (20) @(negedge clock);
      run_frame(8'hFF, 1, 30, 0, 0, 0);
      run_frame(8'h5A, 1, 30, 4, 0, 0);     // clock glitch during BITS

      for (int i = 0; i < 6; i++) begin
         rb = 8'($urandom);
         run_frame(rb, ($urandom_range(0, 3) != 0), $urandom_range(25, 40),
                   $urandom_range(0, 10), 0, 0);
      end

      chk("total_done", n_done, exp_done);
      chk("total_err", n_err, exp_err);
      chk("done_width", n_done_cyc, n_done);
      chk("err_width", n_err_cyc, n_err);
      chk("done_err_overlap", n_both, 0);
      chk("busy_at_pulse", n_busy_at_pulse, 0);
      chk("oe_at_err", n_oe_at_err, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
